// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU built from one 1-bit slice with a registered carry.
// Operands are consumed LSB first, one bit per clock, and the assembled word is
// published on result only when the last bit has been processed.
module serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_invert,
  input  logic             b_invert,
  input  logic [1:0]       operation,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, next_state;

  // Latched request: operands shift right each bit so bit 0 is always the live bit.
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             a_inv_r, b_inv_r;
  logic [1:0]       op_r;
  logic             carry;
  logic [CW-1:0]    count;
  // Holds the bits produced so far; the newest bit enters at the top.
  logic [WIDTH-2:0] partial;

  logic             accept;
  logic             last_bit;
  logic             ai, bi, sum, cout, slice_bit, ovf, set_bit;
  logic [WIDTH-1:0] slice_word, final_word;

  // A new request is taken whenever no operation is in flight; DONE counts as free.
  assign accept   = start && (state != RUN);
  assign last_bit = (state == RUN) && (count == LAST);

  // State register; reset forces IDLE and aborts any operation silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = start ? RUN : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // One bit slice: inverted inputs, full adder, logic ops and the SLT set bit.
  always_comb begin
    ai        = a_sh[0] ^ a_inv_r;
    bi        = b_sh[0] ^ b_inv_r;
    sum       = ai ^ bi ^ carry;
    cout      = (ai & bi) | (ai & carry) | (bi & carry);
    slice_bit = sum;
    case (op_r)
      2'b00:   slice_bit = ai & bi;
      2'b01:   slice_bit = ai | bi;
      default: slice_bit = sum;
    endcase
    // On the MSB the incoming carry is the carry into the sign bit.
    ovf        = carry ^ cout;
    set_bit    = sum ^ ovf;
    slice_word = {slice_bit, partial};
    final_word = (op_r == 2'b11) ? {{(WIDTH-1){1'b0}}, set_bit} : slice_word;
  end

  // Datapath: latch on accept, shift one bit per RUN cycle, publish on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      a_inv_r  <= 1'b0;
      b_inv_r  <= 1'b0;
      op_r     <= 2'b00;
      carry    <= 1'b0;
      count    <= '0;
      partial  <= '0;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      a_inv_r <= a_invert;
      b_inv_r <= b_invert;
      op_r    <= operation;
      carry   <= b_invert;
      count   <= '0;
      partial <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      carry   <= cout;
      count   <= count + 1'b1;
      partial <= slice_word[WIDTH-1:1];
      if (last_bit) begin
        result   <= final_word;
        zero     <= (final_word == '0);
        overflow <= (op_r == 2'b10) ? ovf : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: randomized and directed scoreboard bench for serial_alu.
module tb_serial_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         a_invert, b_invert;
  logic [1:0]   operation;
  logic         busy, done;
  logic [W-1:0] result;
  logic         zero, overflow;

  serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .a_invert  (a_invert),
    .b_invert  (b_invert),
    .operation (operation),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to check the done latency.
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t sb[$];

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Reference model: whole-word arithmetic on the (optionally inverted) operands.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ai, input logic bi, input logic [1:0] op);
    exp_t         e;
    logic [W-1:0] x, y, s;
    logic [W:0]   wide;
    logic         v;
    x    = ai ? ~av : av;
    y    = bi ? ~bv : bv;
    wide = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, bi};
    s    = wide[W-1:0];
    v    = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    case (op)
      2'b00:   e.res = x & y;
      2'b01:   e.res = x | y;
      2'b10:   e.res = s;
      default: e.res = {{(W-1){1'b0}}, s[W-1] ^ v};
    endcase
    e.zero = (e.res == '0);
    e.ovf  = (op == 2'b10) ? v : 1'b0;
    e.due  = 0;
    return e;
  endfunction

  // Drive one start pulse from a negedge and queue its expected response.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic ai, input logic bi, input logic [1:0] op);
    exp_t e;
    a         = av;
    b         = bv;
    a_invert  = ai;
    b_invert  = bi;
    operation = op;
    start     = 1'b1;
    e         = model(av, bv, ai, bi, op);
    e.due     = cycle + W + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait, with a bound, until done is observed at a negedge.
  task automatic waitDone(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < W + 8 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL %s timeout: got no done, required done within %0d cycles", name, W + 8);
    end
  endtask

  task automatic runOp(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ai, input logic bi, input logic [1:0] op);
    applyStimulus(av, bv, ai, bi, op);
    waitDone("op");
    @(negedge clk);
  endtask

  // Monitor: every done pulse pops one expectation and compares it.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got done=1, required done=0 at cycle %0d", cycle);
      end else begin
        e = sb.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("zero", W'(zero), W'(e.zero));
        checkOutput("overflow", W'(overflow), W'(e.ovf));
        checkOutput("latency", W'(cycle), W'(e.due));
        checkOutput("busy_in_done", W'(busy), '0);
      end
    end
  end

  // Main stimulus sequence.
  initial begin : stim
    exp_t first;
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    a_invert  = 1'b0;
    b_invert  = 1'b0;
    operation = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_busy", W'(busy), '0);
    checkOutput("reset_done", W'(done), '0);
    checkOutput("reset_result", result, '0);
    checkOutput("reset_zero", W'(zero), W'(1'b1));
    checkOutput("reset_overflow", W'(overflow), '0);

    runOp(32'd7, 32'd5, 1'b0, 1'b0, 2'b10);
    runOp(32'd5, 32'd7, 1'b0, 1'b1, 2'b10);
    runOp(32'd5, 32'd7, 1'b0, 1'b1, 2'b11);
    runOp(32'd7, 32'd5, 1'b0, 1'b1, 2'b11);
    runOp(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 2'b10);
    runOp(32'h80000000, 32'd1, 1'b0, 1'b1, 2'b11);
    runOp(32'hF0F0F0F0, 32'h0F0F00FF, 1'b1, 1'b1, 2'b00);
    runOp(32'hF0F0F0F0, 32'h0F0F00FF, 1'b0, 1'b0, 2'b01);
    runOp(32'h12345678, 32'h12345678, 1'b0, 1'b1, 2'b10);

    // A start pulse mid-RUN must leave the in-flight op untouched.
    applyStimulus(32'd100, 32'd200, 1'b0, 1'b0, 2'b10);
    repeat (9) @(negedge clk);
    a         = 32'hDEADBEEF;
    b         = 32'h0BADF00D;
    operation = 2'b00;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_ignore_start", W'(busy), W'(1'b1));
    waitDone("ignored_start");
    @(negedge clk);

    // Back-to-back: start held in DONE is accepted; result holds until the next DONE.
    first = model(32'd1000, 32'd234, 1'b0, 1'b0, 2'b10);
    applyStimulus(32'd1000, 32'd234, 1'b0, 1'b0, 2'b10);
    waitDone("b2b_first");
    applyStimulus(32'hCAFE0000, 32'h0000BABE, 1'b0, 1'b0, 2'b01);
    checkOutput("b2b_busy", W'(busy), W'(1'b1));
    checkOutput("b2b_result_held", result, first.res);
    waitDone("b2b_second");
    @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse.
    applyStimulus(32'd11, 32'd22, 1'b0, 1'b0, 2'b10);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", W'(busy), '0);
    checkOutput("abort_done", W'(done), '0);
    checkOutput("abort_result", result, '0);
    checkOutput("abort_zero", W'(zero), W'(1'b1));
    repeat (W + 4) @(negedge clk);
    runOp(32'd40, 32'd2, 1'b0, 1'b0, 2'b10);

    // Randomized operations with random flags.
    for (int i = 0; i < 40; i++) begin
      runOp($urandom, $urandom, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
            2'($urandom_range(3, 0)));
    end

    repeat (3) @(negedge clk);
    checkOutput("pending_expectations", W'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
